// File: rtl/ram_sync_ctl.sv
// ram_sync_ctl: synchronous word RAM with req/ack handshake,
// programmable read wait states and a clear sweep after reset.
//
// Parameters: DATA_W (word width), ADDR_W (depth = 2**ADDR_W),
//   WAIT_STATES (0..15 extra cycles before ack), CLEAR_ON_RESET.
// Ports:
//   clk, reset    rising-edge clock, async active-high reset
//   req, we       access request and direction, sampled in IDLE
//   addr, wdata   address and write data, sampled with req
//   rdata         read data, held until the next read completes
//   ack           one-cycle completion pulse
//   busy          clear sweep running or access in flight
//   perr          parity error, valid with ack on reads
// Optional feature: define RAM_PARITY_EN to store an odd parity
// bit alongside every word; otherwise perr is tied low.
module ram_sync_ctl #(
    parameter int DATA_W         = 12,
    parameter int ADDR_W         = 15,
    parameter int WAIT_STATES    = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              perr
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              perr_q, perr_d;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [MEM_W-1:0]  rword;

    // Stored word: data plus (optionally) the bit that makes the
    // total weight odd, so an all-zero word stores parity 1.
    function automatic logic [MEM_W-1:0] encode(
        input logic [DATA_W-1:0] d
    );
`ifdef RAM_PARITY_EN
        return {~^d, d};
`else
        return d;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        perr_d  = 1'b0;
        mem_we  = 1'b0;
        mem_wa  = addr;
        mem_wd  = wdata;
        rword   = mem[addr_q];
        unique case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req) begin
                    addr_d = addr;
                    we_d   = we;
                    wcnt_d = '0;
                    // Writes land at the accept edge so a following
                    // read of the same word sees the new data.
                    mem_we = we;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (wcnt_q == WS_LAST) begin
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
                if (!we_q) begin
                    rdata_d = rword[DATA_W-1:0];
`ifdef RAM_PARITY_EN
                    perr_d = ~^rword;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            perr_q  <= perr_d;
        end
    end

    // The array has no reset; writes are blocked while reset is held
    // so the sweep starts cleanly from word 0 on release.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_wa] <= encode(mem_wd);
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = (state_q != S_IDLE);
`ifdef RAM_PARITY_EN
    assign perr  = perr_q;
`else
    assign perr  = 1'b0;
`endif

endmodule
